// File: rtl/mesh_route_table.sv
// mesh_route_table
//   XY routing table for one router of a ROWS x COLS mesh. After reset or a
//   rebuild pulse, an init sequencer fills one entry per cycle. Once READY,
//   NUM_PORTS independent lookup ports answer with one cycle of latency. A
//   config port can overwrite single entries.
//
// Ports
//   clk, reset            rising-edge clock, async active-high reset
//   id                    node address, captured when init starts
//   rebuild               pulse in READY restarts init
//   ready                 table valid
//   req_valid/req_addr    per-port lookup request (packed addresses)
//   rsp_valid/rsp_dir/    per-port registered response
//   rsp_err               (rsp_err: destination outside the mesh)
//   cfg_we/cfg_addr/      entry overwrite
//   cfg_dir
//   cfg_err               one-cycle pulse when a write is rejected
//
// state   | meaning
// S_IDLE  | capture id, clear init counters
// S_INIT  | write one XY entry per cycle
// S_READY | serve lookups and config writes
module mesh_route_table #(
  parameter int COLS      = 3,
  parameter int ROWS      = 3,
  parameter int ADDR_SZ   = 4,
  parameter int BITS_DIR  = 3,
  parameter int NUM_PORTS = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [ADDR_SZ-1:0]            id,
  input  logic                          rebuild,
  output logic                          ready,
  input  logic [NUM_PORTS-1:0]          req_valid,
  input  logic [NUM_PORTS*ADDR_SZ-1:0]  req_addr,
  output logic [NUM_PORTS-1:0]          rsp_valid,
  output logic [NUM_PORTS*BITS_DIR-1:0] rsp_dir,
  output logic [NUM_PORTS-1:0]          rsp_err,
  input  logic                          cfg_we,
  input  logic [ADDR_SZ-1:0]            cfg_addr,
  input  logic [BITS_DIR-1:0]           cfg_dir,
  output logic                          cfg_err
);

  localparam int                NODES    = ROWS * COLS;
  // One extra bit so the compare still works when NODES == 2**ADDR_SZ.
  localparam logic [ADDR_SZ:0]   NODES_W  = (ADDR_SZ+1)'(NODES);
  localparam logic [ADDR_SZ-1:0] LAST     = ADDR_SZ'(NODES - 1);
  localparam logic [ADDR_SZ-1:0] COL_LAST = ADDR_SZ'(COLS - 1);

  localparam logic [BITS_DIR-1:0] DIR_N = BITS_DIR'(0);
  localparam logic [BITS_DIR-1:0] DIR_E = BITS_DIR'(1);
  localparam logic [BITS_DIR-1:0] DIR_S = BITS_DIR'(2);
  localparam logic [BITS_DIR-1:0] DIR_W = BITS_DIR'(3);
  localparam logic [BITS_DIR-1:0] DIR_L = BITS_DIR'(4);

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_READY} state_t;

  state_t state_q, state_d;
  logic   capture, init_we;

  logic [ADDR_SZ-1:0]  id_row, id_col;
  logic [ADDR_SZ-1:0]  cnt, cnt_row, cnt_col;
  logic [BITS_DIR-1:0] init_dir;
  logic                cfg_ok;

  logic [BITS_DIR-1:0] mem [2**ADDR_SZ];

  logic [ADDR_SZ-1:0] req_a  [NUM_PORTS];
  logic               req_in [NUM_PORTS];

  function automatic logic [BITS_DIR-1:0] xy(
    input logic [ADDR_SZ-1:0] r,
    input logic [ADDR_SZ-1:0] c,
    input logic [ADDR_SZ-1:0] dr,
    input logic [ADDR_SZ-1:0] dc
  );
    if (dc > c)      return DIR_E;
    else if (dc < c) return DIR_W;
    else if (dr > r) return DIR_S;
    else if (dr < r) return DIR_N;
    else             return DIR_L;
  endfunction

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_INIT;
      S_INIT:  if (cnt == LAST) state_d = S_READY;
      S_READY: if (rebuild) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    capture = (state_q == S_IDLE);
    init_we = (state_q == S_INIT);
    ready   = (state_q == S_READY);
  end

  // ---------------- init counters ----------------
  // Row/col of the entry being written are tracked alongside cnt so that
  // only the node id needs a divide, once per init.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_row  <= '0;
      id_col  <= '0;
      cnt     <= '0;
      cnt_row <= '0;
      cnt_col <= '0;
    end else if (capture) begin
      id_row  <= ADDR_SZ'(32'(id) / COLS);
      id_col  <= ADDR_SZ'(32'(id) % COLS);
      cnt     <= '0;
      cnt_row <= '0;
      cnt_col <= '0;
    end else if (init_we) begin
      cnt <= cnt + ADDR_SZ'(1);
      if (cnt_col == COL_LAST) begin
        cnt_col <= '0;
        cnt_row <= cnt_row + ADDR_SZ'(1);
      end else begin
        cnt_col <= cnt_col + ADDR_SZ'(1);
      end
    end
  end

  assign init_dir = xy(id_row, id_col, cnt_row, cnt_col);

  // rebuild in the same cycle takes priority over a config write.
  assign cfg_ok = ready && !rebuild && ({1'b0, cfg_addr} < NODES_W);

  // ---------------- table storage ----------------
  always_ff @(posedge clk) begin
    if (init_we)
      mem[cnt] <= init_dir;
    else if (cfg_we && cfg_ok)
      mem[cfg_addr] <= cfg_dir;
  end

  // ---------------- lookup ports ----------------
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      req_a[p]  = req_addr[p*ADDR_SZ +: ADDR_SZ];
      req_in[p] = ({1'b0, req_addr[p*ADDR_SZ +: ADDR_SZ]} < NODES_W);
    end
  end

  // Nonblocking read of mem gives read-before-write against a same-cycle
  // config write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid <= '0;
      rsp_dir   <= '0;
      rsp_err   <= '0;
      cfg_err   <= 1'b0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        rsp_valid[p] <= ready && req_valid[p];
        if (ready && req_valid[p]) begin
          if (req_in[p]) begin
            rsp_dir[p*BITS_DIR +: BITS_DIR] <= mem[req_a[p]];
            rsp_err[p]                      <= 1'b0;
          end else begin
            rsp_dir[p*BITS_DIR +: BITS_DIR] <= DIR_L;
            rsp_err[p]                      <= 1'b1;
          end
        end else begin
          rsp_dir[p*BITS_DIR +: BITS_DIR] <= '0;
          rsp_err[p]                      <= 1'b0;
        end
      end
      cfg_err <= cfg_we && !cfg_ok;
    end
  end

endmodule

// File: doc/mesh_route_table.md
# mesh_route_table

Parametrised XY routing table for one router of an R×C mesh NoC. It sits beside the router's input arbitration and answers destination-to-output-direction lookups on several independent ports. After reset, or on request, an init state machine builds the table, writing one entry per cycle. A runtime configuration port can overwrite individual entries, for fault avoidance or custom routes.

## Interface
- COLS, 3, mesh columns (≥1)
- ROWS, 3, mesh rows (≥1)
- ADDR_SZ, 4, node address width; 2^ADDR_SZ ≥ ROWS*COLS
- BITS_DIR, 3, direction width (≥3)
- NUM_PORTS, 2, independent lookup ports (≥1)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  reset, asynchronous, active-high
- id  in  ADDR_SZ  this node's address; row = id / COLS, col = id % COLS
- rebuild  in  1  one-cycle pulse; restarts init from READY
- ready  out  1  table valid, lookups accepted
- req_valid  in  NUM_PORTS  per-port lookup request
- req_addr  in  NUM_PORTS*ADDR_SZ  packed destination addresses; port p at bits [p*ADDR_SZ +: ADDR_SZ]
- rsp_valid  out  NUM_PORTS  per-port response strobe
- rsp_dir  out  NUM_PORTS*BITS_DIR  packed directions
- rsp_err  out  NUM_PORTS  destination ≥ ROWS*COLS
- cfg_we  in  1  entry overwrite strobe
- cfg_addr  in  ADDR_SZ  entry index
- cfg_dir  in  BITS_DIR  new direction
- cfg_err  out  1  one-cycle pulse: write rejected

## Operation
- Direction encoding: 0 = north (row−1), 1 = east (col+1), 2 = south (row+1), 3 = west (col−1), 4 = local.
- XY rule for destination d (row dr, col dc) from node (r, c):
  - dc > c → 1; dc < c → 3.
  - Otherwise dr > r → 2; dr < r → 0.
  - Otherwise → 4.
- States:
  - IDLE: the state on reset. On the next edge, capture id into id_q, set cnt = 0, go to INIT.
  - INIT: write mem[cnt] = xy(id_q, cnt) and increment cnt. At cnt == ROWS*COLS−1, write the last entry and go to READY.
  - READY: lookups and cfg writes are serviced. rebuild → IDLE.
- Only id_q is used; id changes after capture have no effect until the next reset or rebuild.
- Lookup, port p:
  - When req_valid[p] is high in READY, the response is registered.
  - If req_addr ≥ ROWS*COLS: rsp_dir = 4 and rsp_err = 1.
  - Otherwise: rsp_dir = mem[addr] and rsp_err = 0.
- Requests outside READY are dropped: rsp_valid stays 0.
- Ports are fully independent. Any number of ports may read the same entry in the same cycle.
- Config write:
  - In READY with cfg_addr < ROWS*COLS, mem[cfg_addr] ← cfg_dir at the edge.
  - In any other state, or with an out-of-range address, the write is dropped and cfg_err pulses for one cycle.
  - cfg_dir values > 4 are stored unchanged; the block does not check them.
- Write and lookup to the same address in the same cycle: the lookup returns the old value (read-before-write).
- rebuild and cfg_we in the same cycle: rebuild wins, cfg_err pulses, and the write is dropped.
- cfg overwrites are lost on rebuild and on reset.

## Timing
- Reset values:
  - ready = 0, rsp_valid = 0, rsp_dir = 0, rsp_err = 0, cfg_err = 0.
  - State = IDLE, cnt = 0.
  - mem contents are don't-care until INIT completes.
- Assertion of reset clears all state immediately, including mid-INIT and mid-lookup. Any in-flight response is lost.
- Init duration: ready rises after the (ROWS*COLS+1)th rising edge following reset deassert; that is 10 edges for 3×3.
- ready drops on the edge that samples rebuild.
- Lookup latency is 1 cycle:
  - A request sampled at edge N gives rsp_valid/rsp_dir/rsp_err after edge N.
  - These are held for one cycle only; rsp_valid returns to 0 unless a new request arrives.
- Full throughput: one lookup per port per cycle.
- A cfg write at edge N is visible to lookups sampled at edge N+1.

## Test plan
- 3×3, id = 0: reset, count edges until ready → 10. Lookup 0..8 on port 0 → 4,1,1,2,1,1,2,1,1, all with rsp_err = 0.
- 3×3, id = 4: lookup 0..8 split across both ports in the same cycles → 3,0,1,3,4,1,3,2,1. Responses one cycle after each request; rsp_valid drops when requests stop.
- id = 0, READY: cfg_we addr 8 dir 2 while port 1 looks up 8 in the same cycle → response 1. Next lookup of 8 → 2. Pulse rebuild, wait for ready → lookup 8 returns 1 again.
- Lookup addr 12 → rsp_dir = 4, rsp_err = 1. cfg_we addr 9 → cfg_err pulses for one cycle and the table is unchanged.
- Assert reset at the 5th edge of INIT → ready = 0 and all outputs 0 immediately. Lookups and cfg_we during INIT → no rsp_valid, cfg_err pulses. Full re-init completes in 10 edges.
- COLS = 4, ROWS = 2, id = 5: lookup 0..7 → 3,0,1,1,3,4,1,1, with ready after 9 edges.
